// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb3_pkg.sv
// Shared encodings and helpers for the three-requester round-robin arbiter cell.
// Owner/pointer indices are 1..3; 0 means idle / no winner.
package gf180mcu_fd_sc_mcu7t5v0__arb3_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_1    = 2'd1,
        OWN_2    = 2'd2,
        OWN_3    = 2'd3
    } own_t;

    localparam logic [1:0] IDX_IDLE    = 2'd0;
    localparam int         TIMEOUT_DEF = 15;
    localparam int         CNT_W       = 4;

    // Rotate an index 1 -> 2 -> 3 -> 1.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd3) ? 2'd1 : idx + 2'd1;
    endfunction

    // One-hot position of an index within a {R3,R2,R1} vector; idle maps to none.
    function automatic logic [2:0] idx_mask(input logic [1:0] idx);
        logic [2:0] m;
        case (idx)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb3_pick.sv
// Combinational round-robin pick: first asserted request scanning ptr, ptr+1, ptr+2
// with wrap, ignoring the excluded index (0 = exclude nothing).
module gf180mcu_fd_sc_mcu7t5v0__arb3_pick
    import gf180mcu_fd_sc_mcu7t5v0__arb3_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic       r1,
    input  logic       r2,
    input  logic       r3,
    input  logic [1:0] excl,
    output logic [1:0] win
);

    logic [2:0] masked;
    logic [1:0] idx;

    always_comb begin
        win    = IDX_IDLE;
        masked = {r3, r2, r1} & ~idx_mask(excl);
        idx    = ptr;
        for (int i = 0; i < 3; i++) begin
            if (win == IDX_IDLE && (|(masked & idx_mask(idx)))) begin
                win = idx;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb3.sv
// Three-requester round-robin arbiter with registered one-hot hold-until-release grants.
// Optional owner timeout: define GF180MCU_FD_SC_MCU7T5V0__ARB3_TIMEOUT_EN.
//
// state    | meaning
// OWN_IDLE | no grant; pick a winner every edge
// OWN_1..3 | requester k owns the resource until it drops Rk (or times out)
module gf180mcu_fd_sc_mcu7t5v0__arb3
    import gf180mcu_fd_sc_mcu7t5v0__arb3_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic CLK,
    input  logic RST,
    input  logic R1,
    input  logic R2,
    input  logic R3,
    output logic G1,
    output logic G2,
    output logic G3,
    output logic GV
);

    if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_timeout_range
        $error("TIMEOUT must be within 1..15");
    end

    own_t       own_q, own_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win;
    logic [2:0] req;
    logic [2:0] g_q;
    logic       gv_q;
    logic       owner_req;
    logic       others_pend;
    logic       forced;
    logic       take;

    assign req         = {R3, R2, R1};
    assign owner_req   = |(req & idx_mask(own_q));
    assign others_pend = (own_q != OWN_IDLE) && (|(req & ~idx_mask(own_q)));

    // The current owner is always excluded; it only matters on release or pre-emption.
    gf180mcu_fd_sc_mcu7t5v0__arb3_pick u_pick (
        .ptr  (ptr_q),
        .r1   (R1),
        .r2   (R2),
        .r3   (R3),
        .excl (own_q),
        .win  (win)
    );

`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB3_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign forced = others_pend && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = '0;
        if (own_d == own_q && others_pend) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        own_d = own_q;
        ptr_d = ptr_q;
        take  = (own_q == OWN_IDLE) || !owner_req || forced;
        if (take) begin
            own_d = own_t'(win);
            if (win != IDX_IDLE) begin
                ptr_d = next_idx(win);
            end
        end
    end

    // Grants are registered from the next-state value so outputs come straight from flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            own_q <= OWN_IDLE;
            ptr_q <= 2'd1;
            g_q   <= 3'b000;
            gv_q  <= 1'b0;
        end else begin
            own_q <= own_d;
            ptr_q <= ptr_d;
            g_q   <= idx_mask(own_d);
            gv_q  <= (own_d != OWN_IDLE);
        end
    end

    assign G1 = g_q[0];
    assign G2 = g_q[1];
    assign G3 = g_q[2];
    assign GV = gv_q;

    specify
        (CLK => G1) = (1.0, 1.0);
        (CLK => G2) = (1.0, 1.0);
        (CLK => G3) = (1.0, 1.0);
        (CLK => GV) = (1.0, 1.0);
    endspecify

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__arb3.sv
// Directed bench for the arb3 cell: vector table for reset, rotation, single requester
// and mid-grant reset, then a hand-written owner-timeout sequence (either build).
module tb_gf180mcu_fd_sc_mcu7t5v0__arb3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic R1 = 1'b0, R2 = 1'b0, R3 = 1'b0;
    logic G1, G2, G3, GV;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef USE_POWER_PINS
    tri1 VDD;
    tri0 VSS;
`endif

    gf180mcu_fd_sc_mcu7t5v0__arb3 #(.TIMEOUT(4)) dut (
`ifdef USE_POWER_PINS
        .VDD (VDD),
        .VSS (VSS),
`endif
        .CLK (CLK),
        .RST (RST),
        .R1  (R1),
        .R2  (R2),
        .R3  (R3),
        .G1  (G1),
        .G2  (G2),
        .G3  (G3),
        .GV  (GV)
    );

    always #5 CLK = ~CLK;

    // r = {R1,R2,R3}; g = {G1,G2,G3}; expectations hold after the edge the inputs precede.
    typedef struct {
        logic       rst;
        logic [2:0] r;
        logic [2:0] g;
        logic       gv;
    } vec_t;

    vec_t vecs[25];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int g1_cycles;
        logic g2_seen;

        vecs[0]  = '{1'b1, 3'b111, 3'b000, 1'b0};  // reset beats pending requests
        vecs[1]  = '{1'b1, 3'b111, 3'b000, 1'b0};
        vecs[2]  = '{1'b0, 3'b111, 3'b100, 1'b1};  // first edge after reset: R1
        vecs[3]  = '{1'b0, 3'b111, 3'b100, 1'b1};
        vecs[4]  = '{1'b0, 3'b011, 3'b010, 1'b1};  // R1 releases -> R2, no bubble
        vecs[5]  = '{1'b0, 3'b111, 3'b010, 1'b1};
        vecs[6]  = '{1'b0, 3'b101, 3'b001, 1'b1};  // R2 releases -> R3
        vecs[7]  = '{1'b0, 3'b111, 3'b001, 1'b1};
        vecs[8]  = '{1'b0, 3'b110, 3'b100, 1'b1};  // R3 releases -> R1
        vecs[9]  = '{1'b0, 3'b000, 3'b000, 1'b0};  // release to idle
        vecs[10] = '{1'b0, 3'b010, 3'b010, 1'b1};  // lone R2 pulse
        vecs[11] = '{1'b0, 3'b000, 3'b000, 1'b0};
        vecs[12] = '{1'b0, 3'b010, 3'b010, 1'b1};  // R2 re-request granted at once
        vecs[13] = '{1'b0, 3'b000, 3'b000, 1'b0};
        vecs[14] = '{1'b0, 3'b111, 3'b001, 1'b1};  // ptr=3 -> R3 wins the tie
        vecs[15] = '{1'b0, 3'b111, 3'b001, 1'b1};
        vecs[16] = '{1'b1, 3'b111, 3'b000, 1'b0};  // mid-grant reset
        vecs[17] = '{1'b0, 3'b011, 3'b010, 1'b1};  // ptr back to 1, R1 absent -> R2
        vecs[18] = '{1'b0, 3'b111, 3'b010, 1'b1};
        vecs[19] = '{1'b0, 3'b101, 3'b001, 1'b1};  // ptr=3 -> R3 ahead of R1
        vecs[20] = '{1'b0, 3'b100, 3'b100, 1'b1};
        vecs[21] = '{1'b0, 3'b000, 3'b000, 1'b0};
        vecs[22] = '{1'b0, 3'b101, 3'b001, 1'b1};  // ptr=2 from idle -> R3
        vecs[23] = '{1'b0, 3'b000, 3'b000, 1'b0};
        vecs[24] = '{1'b1, 3'b000, 3'b000, 1'b0};

        for (int i = 0; i < 25; i++) begin
            RST = vecs[i].rst;
            R1  = vecs[i].r[2];
            R2  = vecs[i].r[1];
            R3  = vecs[i].r[0];
            step();
            check($sformatf("vec%0d", i), {28'd0, G1, G2, G3, GV}, {28'd0, vecs[i].g, vecs[i].gv});
        end

        // Owner timeout: R1 held, R2 raised one cycle after G1 appears.
        RST = 1'b1; R1 = 1'b0; R2 = 1'b0; R3 = 1'b0;
        step();
        RST = 1'b0; R1 = 1'b1;
        step();
        check("to_first_grant", {28'd0, G1, G2, G3, GV}, 32'h9);
        step();
        check("to_hold", {28'd0, G1, G2, G3, GV}, 32'h9);
        R2 = 1'b1;
        g1_cycles = 2;
        g2_seen   = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ARB3_TIMEOUT_EN
        for (int i = 0; i < 20 && G1; i++) begin
            step();
            if (G1) g1_cycles++;
        end
        check("to_len", g1_cycles, 5);
        check("to_preempt", {28'd0, G1, G2, G3, GV}, 32'h5);
        R2 = 1'b0;
        step();
        check("to_regrant", {28'd0, G1, G2, G3, GV}, 32'h9);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (G1) g1_cycles++;
            if (G2) g2_seen = 1'b1;
        end
        check("hold_len", g1_cycles, 102);
        check("hold_no_g2", {31'd0, g2_seen}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
